instruction_fetch_tag: RTL and testbench

INSTRUCTION_FETCH_TAG -- requirements
Module: instruction_fetch_tag

---
 rtl/instruction_fetch_tag_pkg.sv | 39 +++
 rtl/instruction_fetch_tag_tag_ram.sv | 35 +++
 rtl/instruction_fetch_tag.sv | 107 ++++++++++
 tb/tb_instruction_fetch_tag.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_tag_pkg.sv
// Shared types and geometry for the instruction fetch / I$ tag lookup stage.
// 4-way, 64-set, 16-byte-line cache: tag=[31:10], set=[9:4], offset=[3:0].
package instruction_fetch_tag_pkg;

  localparam int NUM_WAYS   = 4;
  localparam int NUM_SETS   = 64;
  localparam int TAG_W      = 22;
  localparam int SET_W      = 6;
  localparam int OFFSET_LSB = 0;
  localparam int OFFSET_MSB = 3;
  localparam int SET_LSB    = 4;
  localparam int SET_MSB    = 9;
  localparam int TAG_LSB    = 10;
  localparam int TAG_MSB    = 31;

  typedef struct packed {
    logic                            cache_miss;
    logic                            resume_fetch;
    logic [NUM_WAYS-1:0]             update_tag_en;
    logic [SET_W-1:0]                update_tag_set;
    logic [TAG_W-1:0]                update_tag;
  } ifd_ift_inf_t;

  typedef struct packed {
    logic [31:0]                     pc;
    logic [NUM_WAYS-1:0][TAG_W-1:0]  tags;
    logic [NUM_WAYS-1:0]             valid_bits;
  } ift_ifd_inf_t;

  typedef enum logic {
    ST_RUNNING = 1'b0,
    ST_STALLED = 1'b1
  } fetch_state_e;

  function automatic logic [SET_W-1:0] addr_set(input logic [31:0] addr);
    return addr[SET_MSB:SET_LSB];
  endfunction

endpackage

// File: rtl/instruction_fetch_tag_tag_ram.sv
// One way of the I$ tag store: 64x22, single write port, registered read.
// Only the read register is reset; array contents are left as-is.
module icache_tag_ram
  import instruction_fetch_tag_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [SET_W-1:0] waddr_i,
  input  logic [TAG_W-1:0] wdata_i,
  input  logic [SET_W-1:0] raddr_i,
  output logic [TAG_W-1:0] rdata_o
);

  logic [TAG_W-1:0] mem [NUM_SETS];
  logic [TAG_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  // Read returns the pre-write contents on a same-address collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= mem[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/instruction_fetch_tag.sv
// Fetch PC sequencer plus I$ tag/valid lookup; results are presented one
// cycle after the PC is issued. Misses rewind and stall until resume.
module instruction_fetch_tag
  import instruction_fetch_tag_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wb_do_branch,
  input  logic         wb_icache_invalidate,
  input  logic [31:0]  wb_branch_target,
  input  ifd_ift_inf_t ifd_ift_inf,
  output logic         ift_valid,
  output ift_ifd_inf_t ift_ifd_inf
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  out_pc_q, out_pc_d;
  logic         out_valid_q, out_valid_d;
  logic         issue;

  logic [NUM_WAYS-1:0]            valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0]            valid_rd_q;
  logic [NUM_WAYS-1:0][TAG_W-1:0] tag_rd;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    issue   = 1'b0;
    if (wb_do_branch) begin
      pc_d    = wb_branch_target;
      state_d = ST_RUNNING;
    end else if (ifd_ift_inf.cache_miss) begin
      // Rewind to the fetch currently on the output: that is the one that missed.
      pc_d    = out_pc_q;
      state_d = ST_STALLED;
    end else if (state_q == ST_STALLED) begin
      if (ifd_ift_inf.resume_fetch) begin
        state_d = ST_RUNNING;
        issue   = 1'b1;
        pc_d    = pc_q + 32'd4;
      end
    end else begin
      issue = 1'b1;
      pc_d  = pc_q + 32'd4;
    end
    out_valid_d = issue;
    out_pc_d    = issue ? pc_q : out_pc_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUNNING;
      pc_q        <= RESET_PC;
      out_pc_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_pc_q    <= out_pc_d;
      out_valid_q <= out_valid_d;
    end
  end

  // A tag write to an entry beats a same-edge invalidate of that entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
      end
      valid_rd_q <= '0;
    end else begin
      valid_rd_q <= valid_q[addr_set(pc_q)];
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          if (ifd_ift_inf.update_tag_en[w] && (ifd_ift_inf.update_tag_set == SET_W'(s))) begin
            valid_q[s][w] <= 1'b1;
          end else if (wb_do_branch && wb_icache_invalidate) begin
            valid_q[s][w] <= 1'b0;
          end
        end
      end
    end
  end

  for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_way
    icache_tag_ram u_tag_ram (
      .clk     (clk),
      .rst     (rst),
      .we_i    (ifd_ift_inf.update_tag_en[gi]),
      .waddr_i (ifd_ift_inf.update_tag_set),
      .wdata_i (ifd_ift_inf.update_tag),
      .raddr_i (addr_set(pc_q)),
      .rdata_o (tag_rd[gi])
    );
  end

  always_comb begin
    ift_valid              = out_valid_q;
    ift_ifd_inf.pc         = out_pc_q;
    ift_ifd_inf.tags       = tag_rd;
    ift_ifd_inf.valid_bits = valid_rd_q;
  end

endmodule

// File: tb/tb_instruction_fetch_tag.sv
// Directed bench for instruction_fetch_tag: hand-computed pc/valid/tag
// expectations across run, miss/refill, redirect, invalidate and reset.
module tb_instruction_fetch_tag;
  import instruction_fetch_tag_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         wb_do_branch;
  logic         wb_icache_invalidate;
  logic [31:0]  wb_branch_target;
  ifd_ift_inf_t ifd_ift_inf;
  logic         ift_valid;
  ift_ifd_inf_t ift_ifd_inf;

  int checks_q = 0;
  int errors_q = 0;

  instruction_fetch_tag #(.RESET_PC(32'h0)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .wb_do_branch         (wb_do_branch),
    .wb_icache_invalidate (wb_icache_invalidate),
    .wb_branch_target     (wb_branch_target),
    .ifd_ift_inf          (ifd_ift_inf),
    .ift_valid            (ift_valid),
    .ift_ifd_inf          (ift_ifd_inf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_q++;
    if (got !== exp) begin
      errors_q++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_fetch(input string tag, input logic [31:0] pc, input logic [3:0] vb);
    chk({tag, ".valid"}, 64'(ift_valid), 64'd1);
    chk({tag, ".pc"}, 64'(ift_ifd_inf.pc), 64'(pc));
    chk({tag, ".vbits"}, 64'(ift_ifd_inf.valid_bits), 64'(vb));
  endtask

  task automatic clear_inputs();
    wb_do_branch         = 1'b0;
    wb_icache_invalidate = 1'b0;
    wb_branch_target     = '0;
    ifd_ift_inf          = '0;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    tick(); tick(); tick();

    // Reset state
    chk("rst.valid", 64'(ift_valid), 64'd0);
    chk("rst.pc", 64'(ift_ifd_inf.pc), 64'd0);
    chk("rst.vbits", 64'(ift_ifd_inf.valid_bits), 64'd0);
    chk("rst.tags", 64'(ift_ifd_inf.tags[0]), 64'd0);

    // Sequential run 0,4,8
    rst = 1'b0;
    tick(); expect_fetch("run0", 32'd0, 4'b0000);
    tick(); expect_fetch("run4", 32'd4, 4'b0000);
    tick(); expect_fetch("run8", 32'd8, 4'b0000);

    // Re-reset, miss at pc=0
    rst = 1'b1; tick(); rst = 1'b0;
    tick(); expect_fetch("pre_miss0", 32'd0, 4'b0000);
    ifd_ift_inf.cache_miss = 1'b1;
    tick(); ifd_ift_inf.cache_miss = 1'b0;
    chk("stall0.valid", 64'(ift_valid), 64'd0);
    tick(); chk("stall0b.valid", 64'(ift_valid), 64'd0);
    ifd_ift_inf.resume_fetch = 1'b0;
    ifd_ift_inf.update_tag_en  = 4'b0001;
    ifd_ift_inf.update_tag_set = 6'd0;
    ifd_ift_inf.update_tag     = 22'd0;
    tick(); ifd_ift_inf.update_tag_en = 4'b0000;
    chk("stall0c.valid", 64'(ift_valid), 64'd0);
    ifd_ift_inf.resume_fetch = 1'b1;
    tick(); ifd_ift_inf.resume_fetch = 1'b0;
    expect_fetch("refill0", 32'd0, 4'b0001);
    chk("refill0.tag0", 64'(ift_ifd_inf.tags[0]), 64'd0);
    tick(); expect_fetch("r0_4", 32'd4, 4'b0001);
    tick(); expect_fetch("r0_8", 32'd8, 4'b0001);
    tick(); expect_fetch("r0_12", 32'd12, 4'b0001);
    tick(); expect_fetch("r0_16", 32'd16, 4'b0000);

    // Miss at pc=16, refill way 3 of set 1
    ifd_ift_inf.cache_miss = 1'b1;
    tick(); ifd_ift_inf.cache_miss = 1'b0;
    chk("stall16.valid", 64'(ift_valid), 64'd0);
    ifd_ift_inf.update_tag_en  = 4'b1000;
    ifd_ift_inf.update_tag_set = 6'd1;
    ifd_ift_inf.update_tag     = 22'h2ABCD;
    tick(); ifd_ift_inf.update_tag_en = 4'b0000;
    ifd_ift_inf.resume_fetch = 1'b1;
    tick(); ifd_ift_inf.resume_fetch = 1'b0;
    expect_fetch("refill16", 32'd16, 4'b1000);
    chk("refill16.tag3", 64'(ift_ifd_inf.tags[3]), 64'h2ABCD);

    // Write while running plus a stray resume: fetch stream unaffected
    ifd_ift_inf.update_tag_en  = 4'b0110;
    ifd_ift_inf.update_tag_set = 6'd5;
    ifd_ift_inf.update_tag     = 22'h155;
    ifd_ift_inf.resume_fetch   = 1'b1;
    tick(); clear_inputs();
    expect_fetch("wr_run20", 32'd20, 4'b1000);
    for (int a = 24; a < 80; a += 4) begin
      tick(); chk("seq.pc", 64'(ift_ifd_inf.pc), 64'(a));
    end
    tick(); expect_fetch("set5_80", 32'd80, 4'b0110);
    chk("set5.tag1", 64'(ift_ifd_inf.tags[1]), 64'h155);
    chk("set5.tag2", 64'(ift_ifd_inf.tags[2]), 64'h155);

    // Redirect to 12
    wb_do_branch = 1'b1; wb_branch_target = 32'd12;
    tick(); clear_inputs();
    chk("br12.bubble", 64'(ift_valid), 64'd0);
    tick(); expect_fetch("br12", 32'd12, 4'b0001);
    tick(); expect_fetch("br16", 32'd16, 4'b1000);

    // Redirect with invalidate to 0
    wb_do_branch = 1'b1; wb_icache_invalidate = 1'b1; wb_branch_target = 32'd0;
    tick(); clear_inputs();
    chk("inv.bubble", 64'(ift_valid), 64'd0);
    tick(); expect_fetch("inv0", 32'd0, 4'b0000);
    ifd_ift_inf.cache_miss = 1'b1;
    tick(); ifd_ift_inf.cache_miss = 1'b0;
    chk("inv_stall.valid", 64'(ift_valid), 64'd0);
    ifd_ift_inf.update_tag_en  = 4'b0001;
    ifd_ift_inf.update_tag_set = 6'd0;
    ifd_ift_inf.update_tag     = 22'h3FFFF;
    tick(); ifd_ift_inf.update_tag_en = 4'b0000;
    ifd_ift_inf.resume_fetch = 1'b1;
    tick(); ifd_ift_inf.resume_fetch = 1'b0;
    expect_fetch("inv_refill0", 32'd0, 4'b0001);
    chk("inv_refill0.tag0", 64'(ift_ifd_inf.tags[0]), 64'h3FFFF);
    tick(); tick(); tick();
    tick(); expect_fetch("inv16", 32'd16, 4'b0000);

    // Invalidate with same-edge write to set 2 way 2: write wins
    wb_do_branch = 1'b1; wb_icache_invalidate = 1'b1; wb_branch_target = 32'd32;
    ifd_ift_inf.update_tag_en  = 4'b0100;
    ifd_ift_inf.update_tag_set = 6'd2;
    ifd_ift_inf.update_tag     = 22'h7;
    tick(); clear_inputs();
    chk("invwr.bubble", 64'(ift_valid), 64'd0);
    tick(); expect_fetch("invwr32", 32'd32, 4'b0100);
    chk("invwr32.tag2", 64'(ift_ifd_inf.tags[2]), 64'h7);

    // PC wrap
    wb_do_branch = 1'b1; wb_branch_target = 32'hFFFF_FFFC;
    tick(); clear_inputs();
    tick(); chk("wrap.hi", 64'(ift_ifd_inf.pc), 64'hFFFF_FFFC);
    tick(); chk("wrap.lo", 64'(ift_ifd_inf.pc), 64'h0);

    // Reset mid-stall clears state and valid bits
    ifd_ift_inf.cache_miss = 1'b1;
    tick(); ifd_ift_inf.cache_miss = 1'b0;
    rst = 1'b1;
    tick(); chk("rst_stall.valid", 64'(ift_valid), 64'd0);
    rst = 1'b0;
    tick(); expect_fetch("post_rst0", 32'd0, 4'b0000);
    tick(); expect_fetch("post_rst4", 32'd4, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks_q, errors_q);
    $finish;
  end

endmodule
